// File: rtl/hazard_if.sv
// Hazard controller signal bundle: pipeline status from ID/EX/WB into the
// controller, and stage-register enables, flushes and status back out.
interface hazard_if;
  // Instruction in ID
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  // Instruction in EX
  logic       ex_memtoreg;
  logic [4:0] ex_wbregnum;
  logic       ex_branch_taken;
  logic       ex_eret;
  logic       ex_muldiv_start;
  logic       ex_muldiv_div;
  // Instruction in WB and operator control
  logic       wb_syscall_halt;
  logic       resume;
  // Stage-register control
  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       memwb_en;
  logic       ifid_clr;
  logic       idex_clr;
  logic       exmem_clr;
  logic       idex_bb;
  // Status
  logic       muldiv_busy;
  logic       halted;

  // Pipeline side: drives status, consumes the stage controls
  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt,
           ex_memtoreg, ex_wbregnum, ex_branch_taken, ex_eret,
           ex_muldiv_start, ex_muldiv_div, wb_syscall_halt, resume,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_clr, idex_clr, exmem_clr, idex_bb,
           muldiv_busy, halted
  );

  // Controller side
  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt,
           ex_memtoreg, ex_wbregnum, ex_branch_taken, ex_eret,
           ex_muldiv_start, ex_muldiv_div, wb_syscall_halt, resume,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_clr, idex_clr, exmem_clr, idex_bb,
           muldiv_busy, halted
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch/ERET flushes,
// fixed-latency multiply/divide stalls and a SYSCALL halt that freezes the
// whole pipeline until the operator resumes it. Stage controls are
// combinational; busy/halted status is registered.
module hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave hz
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MULDIV = 2'd1,
    HALT   = 2'd2
  } state_t;

  // The counter holds "stall cycles still to come after this one", so the
  // start cycle loads L-1 and the cycle that sees zero releases the pipe.
  localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT - 1);

  state_t     state;
  state_t     saved_state;
  state_t     next_state;
  state_t     next_saved;
  state_t     eff_state;
  logic [5:0] cnt;
  logic [5:0] next_cnt;

  logic       load_use;
  logic       rs_hit;
  logic       rt_hit;
  logic       resume_cycle;
  logic       frozen;
  logic       halt_req;

  logic       pc_en_c;
  logic       ifid_en_c;
  logic       idex_en_c;
  logic       exmem_en_c;
  logic       memwb_en_c;
  logic       ifid_clr_c;
  logic       idex_clr_c;
  logic       exmem_clr_c;
  logic       idex_bb_c;
  logic       busy_q;
  logic       halted_q;

  // Load-use: EX load writes a nonzero register that the ID instruction reads
  always_comb begin
    rs_hit   = hz.id_use_rs && (hz.id_rs == hz.ex_wbregnum);
    rt_hit   = hz.id_use_rt && (hz.id_rt == hz.ex_wbregnum);
    load_use = hz.ex_memtoreg && (hz.ex_wbregnum != 5'd0) && (rs_hit || rt_hit);
  end

  // Halt bookkeeping: a resume cycle behaves like the saved state with the
  // WB halt request masked so a lingering SYSCALL cannot re-halt at once
  always_comb begin
    resume_cycle = (state == HALT) && hz.resume;
    frozen       = (state == HALT) && !hz.resume;
    eff_state    = resume_cycle ? saved_state : state;
    halt_req     = hz.wb_syscall_halt && (state != HALT);
  end

  // Stage controls and next-state/counter decisions in priority order
  always_comb begin
    pc_en_c     = 1'b1;
    ifid_en_c   = 1'b1;
    idex_en_c   = 1'b1;
    exmem_en_c  = 1'b1;
    memwb_en_c  = 1'b1;
    ifid_clr_c  = 1'b0;
    idex_clr_c  = 1'b0;
    exmem_clr_c = 1'b0;
    idex_bb_c   = 1'b0;
    next_state  = state;
    next_saved  = saved_state;
    next_cnt    = cnt;

    if (frozen) begin
      pc_en_c    = 1'b0;
      ifid_en_c  = 1'b0;
      idex_en_c  = 1'b0;
      exmem_en_c = 1'b0;
      memwb_en_c = 1'b0;
      next_state = HALT;
    end else if (halt_req) begin
      pc_en_c    = 1'b0;
      ifid_en_c  = 1'b0;
      idex_en_c  = 1'b0;
      exmem_en_c = 1'b0;
      memwb_en_c = 1'b0;
      next_saved = state;
      next_state = HALT;
    end else if (eff_state == MULDIV) begin
      if (cnt != 6'd0) begin
        pc_en_c     = 1'b0;
        ifid_en_c   = 1'b0;
        idex_en_c   = 1'b0;
        exmem_clr_c = 1'b1;
        next_cnt    = cnt - 6'd1;
        next_state  = MULDIV;
      end else begin
        next_state = RUN;
      end
    end else begin
      next_state = RUN;
      if (hz.ex_muldiv_start) begin
        pc_en_c     = 1'b0;
        ifid_en_c   = 1'b0;
        idex_en_c   = 1'b0;
        exmem_clr_c = 1'b1;
        next_cnt    = hz.ex_muldiv_div ? DIV_LOAD : MUL_LOAD;
        next_state  = MULDIV;
      end else if (hz.ex_branch_taken || hz.ex_eret) begin
        ifid_clr_c = 1'b1;
        idex_clr_c = 1'b1;
      end else if (load_use) begin
        pc_en_c   = 1'b0;
        ifid_en_c = 1'b0;
        idex_bb_c = 1'b1;
      end
    end
  end

  // State, counter and registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      saved_state <= RUN;
      cnt         <= 6'd0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state       <= next_state;
      saved_state <= next_saved;
      cnt         <= next_cnt;
      busy_q      <= (next_state == MULDIV);
      halted_q    <= (next_state == HALT);
    end
  end

  assign hz.pc_en       = pc_en_c;
  assign hz.ifid_en     = ifid_en_c;
  assign hz.idex_en     = idex_en_c;
  assign hz.exmem_en    = exmem_en_c;
  assign hz.memwb_en    = memwb_en_c;
  assign hz.ifid_clr    = ifid_clr_c;
  assign hz.idex_clr    = idex_clr_c;
  assign hz.exmem_clr   = exmem_clr_c;
  assign hz.idex_bb     = idex_bb_c;
  assign hz.muldiv_busy = busy_q;
  assign hz.halted      = halted_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: reset, a table of single-cycle RUN vectors,
// hand-written multi-cycle sequences and a randomized run against a
// behavioural model.
module tb_hazard_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  // Output vector order: pc_en ifid_en idex_en exmem_en memwb_en
  //                      ifid_clr idex_clr exmem_clr idex_bb
  localparam logic [8:0] O_DEF   = 9'b11111_0000;
  localparam logic [8:0] O_LU    = 9'b00111_0001;
  localparam logic [8:0] O_FLUSH = 9'b11111_1100;
  localparam logic [8:0] O_MD    = 9'b00011_0010;
  localparam logic [8:0] O_HALT  = 9'b00000_0000;

  localparam int M_RUN  = 0;
  localparam int M_MUL  = 1;
  localparam int M_HALT = 2;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       m2r;
    logic [4:0] wb;
    logic       br;
    logic       eret;
    logic       start;
    logic       div;
    logic       halt;
    logic       resume;
  } in_t;

  typedef struct {
    string      name;
    in_t        stim;
    logic [8:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  hazard_if hz ();

  hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: mode, saved mode, latency of current op and stalls done
  int m_mode  = M_RUN;
  int m_saved = M_RUN;
  int m_lat   = 0;
  int m_done  = 0;

  function automatic in_t idle_in();
    in_t s;
    s.rs = 0; s.rt = 0; s.use_rs = 0; s.use_rt = 0; s.m2r = 0; s.wb = 0;
    s.br = 0; s.eret = 0; s.start = 0; s.div = 0; s.halt = 0; s.resume = 0;
    return s;
  endfunction

  function automatic in_t lu_in(input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt, input logic m2r,
                                input logic [4:0] wb, input logic br, input logic eret);
    in_t s;
    s = idle_in();
    s.rs = rs; s.rt = rt; s.use_rs = urs; s.use_rt = urt;
    s.m2r = m2r; s.wb = wb; s.br = br; s.eret = eret;
    return s;
  endfunction

  task automatic applyStimulus(input in_t s);
    hz.id_rs           = s.rs;
    hz.id_rt           = s.rt;
    hz.id_use_rs       = s.use_rs;
    hz.id_use_rt       = s.use_rt;
    hz.ex_memtoreg     = s.m2r;
    hz.ex_wbregnum     = s.wb;
    hz.ex_branch_taken = s.br;
    hz.ex_eret         = s.eret;
    hz.ex_muldiv_start = s.start;
    hz.ex_muldiv_div   = s.div;
    hz.wb_syscall_halt = s.halt;
    hz.resume          = s.resume;
  endtask

  function automatic logic [10:0] dut_out();
    return {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
            hz.ifid_clr, hz.idex_clr, hz.exmem_clr, hz.idex_bb,
            hz.muldiv_busy, hz.halted};
  endfunction

  task automatic checkOutput(input string name, input logic [10:0] exp);
    logic [10:0] got;
    got = dut_out();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RUN; m_saved = M_RUN; m_lat = 0; m_done = 0;
  endtask

  // Behavioural reference: one call per clock cycle, returns expected outputs
  task automatic model_step(input in_t s, output logic [10:0] exp);
    logic [8:0] o;
    logic       lu;
    int         act;
    bit         hlt;
    o   = O_DEF;
    exp = {9'b0, (m_mode == M_MUL), (m_mode == M_HALT)};
    lu  = s.m2r && (s.wb != 0) &&
          ((s.use_rs && s.rs == s.wb) || (s.use_rt && s.rt == s.wb));
    if (m_mode == M_HALT && !s.resume) begin
      o = O_HALT;
    end else begin
      act = (m_mode == M_HALT) ? m_saved : m_mode;
      hlt = (m_mode != M_HALT) && s.halt;
      if (hlt) begin
        o = O_HALT;
        m_saved = m_mode;
        m_mode  = M_HALT;
      end else if (act == M_MUL) begin
        if (m_done < m_lat) begin
          o = O_MD;
          m_done++;
          m_mode = M_MUL;
        end else begin
          m_mode = M_RUN;
        end
      end else begin
        m_mode = M_RUN;
        if (s.start) begin
          o      = O_MD;
          m_lat  = s.div ? DIV_LAT : MUL_LAT;
          m_done = 1;
          m_mode = M_MUL;
        end else if (s.br || s.eret) begin
          o = O_FLUSH;
        end else if (lu) begin
          o = O_LU;
        end
      end
    end
    exp[10:2] = o;
  endtask

  task automatic idle_cycles(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); applyStimulus(idle_in()); #1;
      checkOutput(name, {O_DEF, 2'b00});
    end
  endtask

  // Hold a mul/div start in EX until the pipe is released, counting stalls
  task automatic muldiv_seq(input bit div, input int lat, input string name);
    in_t s;
    int  pc_low = 0;
    int  busy_stall = 0;
    bit  done = 0;
    s = idle_in(); s.start = 1; s.div = div;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk); applyStimulus(s); #1;
      if (!hz.pc_en) begin
        pc_low++;
        if (hz.muldiv_busy) busy_stall++;
      end else begin
        done = 1;
      end
    end
    checkCount({name, "_finished"}, int'(done), 1);
    checkCount({name, "_pc_low"}, pc_low, lat);
    if (!div) checkCount({name, "_busy_stall"}, busy_stall, lat - 1);
    idle_cycles(2, {name, "_after"});
  endtask

  vec_t vecs[$];

  initial begin
    in_t         s;
    logic [10:0] exp;
    int          pc_low;
    int          halted_n;
    bit          done;

    // Reset state
    rst = 1'b1;
    applyStimulus(idle_in());
    #2;
    checkOutput("reset_state", {O_DEF, 2'b00});
    @(negedge clk); rst = 1'b0;

    // Single-cycle RUN vectors
    vecs.push_back('{"idle",          idle_in(),                          O_DEF});
    vecs.push_back('{"lu_rs",         lu_in(5, 0, 1, 0, 1, 5, 0, 0),      O_LU});
    vecs.push_back('{"lu_rt",         lu_in(0, 7, 0, 1, 1, 7, 0, 0),      O_LU});
    vecs.push_back('{"lu_r0",         lu_in(0, 0, 1, 1, 1, 0, 0, 0),      O_DEF});
    vecs.push_back('{"lu_unused_rs",  lu_in(5, 0, 0, 0, 1, 5, 0, 0),      O_DEF});
    vecs.push_back('{"not_load",      lu_in(5, 5, 1, 1, 0, 5, 0, 0),      O_DEF});
    vecs.push_back('{"reg_differs",   lu_in(5, 9, 1, 1, 1, 6, 0, 0),      O_DEF});
    vecs.push_back('{"lu_rs_only",    lu_in(12, 3, 1, 1, 1, 12, 0, 0),    O_LU});
    vecs.push_back('{"branch_over_lu", lu_in(5, 0, 1, 0, 1, 5, 1, 0),     O_FLUSH});
    vecs.push_back('{"eret_over_lu",  lu_in(0, 8, 0, 1, 1, 8, 0, 1),      O_FLUSH});
    vecs.push_back('{"branch_only",   lu_in(0, 0, 0, 0, 0, 0, 1, 0),      O_FLUSH});
    foreach (vecs[i]) begin
      @(negedge clk); applyStimulus(vecs[i].stim); #1;
      checkOutput(vecs[i].name, {vecs[i].exp, 2'b00});
    end

    // Load-use stall lasts one cycle: EX becomes a bubble afterwards
    pc_low = 0;
    @(negedge clk); applyStimulus(lu_in(5, 0, 1, 0, 1, 5, 0, 0)); #1;
    if (!hz.pc_en) pc_low++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); applyStimulus(lu_in(5, 0, 1, 0, 0, 0, 0, 0)); #1;
      if (!hz.pc_en) pc_low++;
    end
    checkCount("lu_stall_cycles", pc_low, 1);

    // Multiply and divide stalls
    muldiv_seq(1'b0, MUL_LAT, "mul");
    muldiv_seq(1'b1, DIV_LAT, "div");

    // SYSCALL halt in RUN, hold, resume
    s = idle_in(); s.halt = 1;
    @(negedge clk); applyStimulus(s); #1;
    checkOutput("halt_cycle", {O_HALT, 2'b00});
    s = lu_in(5, 0, 1, 0, 1, 5, 1, 0); s.start = 1; s.halt = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); applyStimulus(s); #1;
      checkOutput("halt_hold", {O_HALT, 2'b01});
    end
    s = idle_in(); s.resume = 1; s.halt = 1;
    @(negedge clk); applyStimulus(s); #1;
    checkOutput("resume_cycle", {O_DEF, 2'b01});
    idle_cycles(2, "after_resume");

    // Halt during a divide: halt after 5 stalls, 7 hold cycles, then resume
    pc_low = 0; halted_n = 0; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      s = idle_in(); s.start = 1; s.div = 1;
      s.halt   = (c == 5);
      s.resume = (c == 13);
      @(negedge clk); applyStimulus(s); #1;
      if (hz.halted) halted_n++;
      if (!hz.pc_en) pc_low++;
      else done = 1;
    end
    checkCount("haltdiv_finished", int'(done), 1);
    checkCount("haltdiv_halted_cycles", halted_n, 8);
    checkCount("haltdiv_pc_low", pc_low, DIV_LAT + 8);
    idle_cycles(2, "haltdiv_after");

    // Reset on stall cycle 10 of a divide
    s = idle_in(); s.start = 1; s.div = 1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk); applyStimulus(s);
    end
    #1;
    checkOutput("rstdiv_stalling", {O_MD, 2'b10});
    @(negedge clk); rst = 1'b1; applyStimulus(idle_in()); #1;
    checkOutput("rstdiv_immediate", {O_DEF, 2'b00});
    @(negedge clk); rst = 1'b0; #1;
    checkOutput("rstdiv_release", {O_DEF, 2'b00});
    idle_cycles(3, "rstdiv_after");

    // Randomized run against the reference model
    @(negedge clk); rst = 1'b1; applyStimulus(idle_in());
    @(negedge clk); rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      s.rs     = 5'($urandom_range(0, 3));
      s.rt     = 5'($urandom_range(0, 3));
      s.wb     = 5'($urandom_range(0, 3));
      s.use_rs = 1'($urandom_range(0, 1));
      s.use_rt = 1'($urandom_range(0, 1));
      s.m2r    = 1'($urandom_range(0, 1));
      s.br     = ($urandom_range(0, 7) == 0);
      s.eret   = ($urandom_range(0, 15) == 0);
      s.start  = ($urandom_range(0, 9) == 0);
      s.div    = ($urandom_range(0, 3) == 0);
      s.halt   = ($urandom_range(0, 24) == 0);
      s.resume = ($urandom_range(0, 2) == 0);
      if (m_mode == M_HALT && s.resume && m_saved == M_RUN) s.start = 0;
      @(negedge clk); applyStimulus(s); #1;
      model_step(s, exp);
      checkOutput("random", exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
